// File: rtl/shot_control_if.sv
// Player-input / launch-output bundle between the key front end, shot_control
// and the tank bullet block.
interface shot_control_if;
  logic       fire_key;
  logic       left_key;
  logic       right_key;
  logic       shoot;
  logic [1:0] Direction;
  logic [9:0] y_component;
  logic [3:0] charge_level;
  logic       busy;

  modport master (
    output fire_key, left_key, right_key,
    input  shoot, Direction, y_component, charge_level, busy
  );

  modport slave (
    input  fire_key, left_key, right_key,
    output shoot, Direction, y_component, charge_level, busy
  );
endinterface

// File: rtl/shot_control.sv
// Hold-to-charge, release-to-fire launcher feeding the tank bullet block.
// One state step per video frame; a cooldown blocks re-fire until the key is released.
module shot_control #(
  parameter int CHARGE_MAX = 15,
  parameter int CHARGE_DIV = 4,
  parameter int MIN_VY     = 2,
  parameter int COOLDOWN   = 60
) (
  input logic           frame_clk,
  input logic           Reset,
  shot_control_if.slave bus
);

  localparam int DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHARGE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN - 1);
  localparam logic [3:0]       CHG_SAT  = 4'(CHARGE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHARGE   = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [3:0]       charge_r, charge_next_s;
  logic [DIV_W-1:0] div_r, div_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [9:0]       y_r, y_next_s;
  logic [1:0]       dir_r, dir_next_s;
  logic             shoot_r, busy_r;

  // Next-state, charge/divider, cooldown counter and launch-velocity latch.
  always_comb begin
    state_next_s  = state_r;
    charge_next_s = charge_r;
    div_next_s    = div_r;
    cnt_next_s    = cnt_r;
    y_next_s      = y_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.fire_key) begin
          state_next_s  = ST_CHARGE;
          charge_next_s = 4'd0;
          div_next_s    = '0;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_CHARGE: begin
        if (bus.fire_key) begin
          if (div_r == DIV_LAST) begin
            div_next_s = '0;
            if (charge_r < CHG_SAT) begin
              charge_next_s = charge_r + 4'd1;
            end else begin
              charge_next_s = CHG_SAT;
            end
          end else begin
            div_next_s = div_r + DIV_W'(1);
          end
        end else begin
          // Release wins over a same-frame divider wrap: launch with the current charge.
          y_next_s      = 10'd0 - (10'(MIN_VY) + {6'd0, charge_r});
          charge_next_s = 4'd0;
          div_next_s    = '0;
          state_next_s  = ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_next_s  = ST_COOLDOWN;
        cnt_next_s    = CNT_INIT;
        charge_next_s = 4'd0;
      end
      ST_COOLDOWN: begin
        if (cnt_r != '0) begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end else if (!bus.fire_key) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_COOLDOWN;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        charge_next_s = 4'd0;
        div_next_s    = '0;
        cnt_next_s    = '0;
      end
    endcase
  end

  // Steering latch; frozen while a bullet is in flight.
  always_comb begin
    dir_next_s = dir_r;
    if ((state_r == ST_IDLE) || (state_r == ST_CHARGE)) begin
      if (bus.left_key && !bus.right_key) begin
        dir_next_s = 2'b00;
      end else if (bus.right_key && !bus.left_key) begin
        dir_next_s = 2'b01;
      end else begin
        dir_next_s = dir_r;
      end
    end else begin
      dir_next_s = dir_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      charge_r <= 4'd0;
      div_r    <= '0;
      cnt_r    <= '0;
      y_r      <= 10'd0;
      dir_r    <= 2'b01;
      shoot_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      charge_r <= charge_next_s;
      div_r    <= div_next_s;
      cnt_r    <= cnt_next_s;
      y_r      <= y_next_s;
      dir_r    <= dir_next_s;
      shoot_r  <= (state_next_s == ST_FIRE);
      busy_r   <= (state_next_s == ST_FIRE) || (state_next_s == ST_COOLDOWN);
    end
  end

  assign bus.shoot        = shoot_r;
  assign bus.Direction    = dir_r;
  assign bus.y_component  = y_r;
  assign bus.charge_level = charge_r;
  assign bus.busy         = busy_r;

endmodule
